// File: rtl/bit_reader_pkg.sv
// rtl/bit_reader_pkg.sv - shared deflate constants, reader state type and field mask helper
package bit_reader_pkg;

    localparam int ADDR_W   = 16;
    localparam int MAX_BITS = 16;
    localparam int BUF_W    = 32;
    localparam int CNT_W    = $clog2(BUF_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Low n bits set; n >= BUF_W yields all ones.
    function automatic logic [BUF_W-1:0] mask(input logic [CNT_W-1:0] n);
        logic [BUF_W-1:0] ones;
        ones = '1;
        return ~(ones << n);
    endfunction

endpackage

// File: rtl/bit_reader_buf.sv
// rtl/bit_reader_buf.sv - bit buffer datapath: consume/align shift, byte append, fill count
module bit_reader_buf
    import bit_reader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                align,
    input  logic                consume,
    input  logic [4:0]          nbits,
    input  logic                append,
    input  logic [7:0]          append_data,
    output logic [MAX_BITS-1:0] head,
    output logic [CNT_W-1:0]    count,
    output logic [CNT_W-1:0]    count_next
);

    logic [BUF_W-1:0] buffer;
    logic [BUF_W-1:0] buffer_kept;
    logic [BUF_W-1:0] buffer_next;
    logic [CNT_W-1:0] shamt;
    logic [CNT_W-1:0] count_kept;

    // Bits above count are always zero, so a plain right shift both consumes
    // and keeps the upper region clean for the next byte to be OR-ed in.
    always_comb begin
        shamt = '0;
        if (align) begin
            shamt = {{(CNT_W-3){1'b0}}, count[2:0]};
        end else if (consume) begin
            shamt = CNT_W'(nbits);
        end
        count_kept  = count - shamt;
        buffer_kept = buffer >> shamt;
        count_next  = count_kept;
        buffer_next = buffer_kept;
        if (clear) begin
            count_next  = '0;
            buffer_next = '0;
        end else if (append) begin
            count_next  = count_kept + CNT_W'(8);
            buffer_next = buffer_kept | (BUF_W'(append_data) << count_kept);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer <= '0;
            count  <= '0;
        end else begin
            buffer <= buffer_next;
            count  <= count_next;
        end
    end

    assign head = buffer[MAX_BITS-1:0];

endmodule

// File: rtl/bit_reader.sv
// rtl/bit_reader.sv - LSB-first DEFLATE bit reader over byte RAM; BIT_READER_PEEK_EN adds peek_data/peek_cnt
module bit_reader
    import bit_reader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     len_bytes,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_rd_data,
    input  logic                rd_req,
    input  logic [4:0]          rd_nbits,
    output logic                rd_valid,
    output logic [MAX_BITS-1:0] rd_data,
    output logic                rd_err,
    input  logic                align,
    output logic                busy,
    output logic                eos
`ifdef BIT_READER_PEEK_EN
    ,
    output logic [MAX_BITS-1:0] peek_data,
    output logic [5:0]          peek_cnt
`endif
);

    state_t              state;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W:0]     remaining;
    logic                data_due;

    logic [MAX_BITS-1:0] head;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;

    logic                req_live;
    logic                too_wide;
    logic                fits;
    logic                starved;
    logic                req_ok;
    logic                req_err;
    logic                do_align;
    logic                issue;
    logic                eos_next;
    logic [CNT_W:0]      fill_level;
    logic [MAX_BITS-1:0] field;

    always_comb begin
        req_live = rd_req && !rd_valid && !align && !start;
        too_wide = rd_nbits > 5'(MAX_BITS);
        fits     = CNT_W'(rd_nbits) <= count;
        starved  = (remaining == '0) && !mem_rd_en && !data_due;
        req_ok   = req_live && !too_wide && fits;
        req_err  = req_live && (too_wide || (!fits && starved));
        do_align = align && !start;
        field    = head & MAX_BITS'(mask(CNT_W'(rd_nbits)));
        // A strobe issued now lands two cycles out; reserve room for it and
        // for the byte already on its way back.
        fill_level = {1'b0, count_next} + (mem_rd_en ? (CNT_W+1)'(8) : '0);
        issue      = (state == RUN) && (remaining != '0)
                     && (fill_level <= (CNT_W+1)'(BUF_W - 8));
        eos_next   = (state == RUN) && (remaining == '0) && !mem_rd_en
                     && (count_next == '0);
    end

    bit_reader_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .clear       (start),
        .align       (do_align),
        .consume     (req_ok),
        .nbits       (rd_nbits),
        .append      (data_due),
        .append_data (mem_rd_data),
        .head        (head),
        .count       (count),
        .count_next  (count_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            next_addr <= '0;
            remaining <= '0;
            data_due  <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
            busy      <= 1'b0;
            eos       <= 1'b0;
        end else if (start) begin
            // Clearing data_due drops whatever the old stream still has in flight.
            state    <= RUN;
            data_due <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
            if (len_bytes != '0) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= base_addr;
                next_addr <= base_addr + ADDR_W'(1);
                remaining <= len_bytes - (ADDR_W+1)'(1);
                busy      <= 1'b1;
                eos       <= 1'b0;
            end else begin
                mem_rd_en <= 1'b0;
                next_addr <= base_addr;
                remaining <= len_bytes;
                busy      <= 1'b0;
                eos       <= 1'b1;
            end
        end else begin
            data_due  <= mem_rd_en;
            rd_valid  <= req_ok || req_err;
            rd_err    <= req_err;
            rd_data   <= req_ok ? field : '0;
            mem_rd_en <= issue;
            if (issue) begin
                mem_addr  <= next_addr;
                next_addr <= next_addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
            eos  <= eos_next;
            busy <= (state == RUN) && !eos_next;
        end
    end

`ifdef BIT_READER_PEEK_EN
    assign peek_data = head;
    assign peek_cnt  = (count > CNT_W'(MAX_BITS)) ? 6'(MAX_BITS) : 6'(count);
`endif

endmodule
